// File: rtl/pyramid_reader.sv
// pyramid_reader: streams one stored pyramid image from BRAM port B in raster order
module pyramid_reader #(
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 128,
    parameter int BIT_DEPTH   = 8,
    parameter int NUM_OCTAVES = 4,
    parameter int NUM_BLURS   = 5,
    parameter int ADDR_WIDTH  = $clog2(NUM_BLURS * WIDTH * HEIGHT * 2),
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [1:0]            octave_in,
    input  logic [2:0]            blur_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  error_out,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic                  bram_en_out,
    input  logic [BIT_DEPTH-1:0]  bram_data_in,
    output logic [BIT_DEPTH-1:0]  pixel_out,
    output logic [7:0]            pixel_x_out,
    output logic [7:0]            pixel_y_out,
    output logic                  pixel_last_out,
    output logic                  pixel_valid_out,
    input  logic                  pixel_ready_in
);
    localparam int LW = $clog2(WIDTH);
    localparam int LH = $clog2(HEIGHT);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = BIT_DEPTH + 17;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    function automatic logic [ADDR_WIDTH-1:0] base_of(input int o);
        int s;
        s = 0;
        for (int k = 0; k < o; k++) s += NUM_BLURS * (WIDTH >> k) * (HEIGHT >> k);
        return ADDR_WIDTH'(s);
    endfunction

    state_t                  state;
    logic [1:0]              oct;
    logic [2:0]              blur;
    logic [7:0]              x, y, x_max, y_max;
    logic [4:0]              sh_w, sh_hw;
    logic [CW-1:0]           credits, count;
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [EW-1:0]           mem [FIFO_DEPTH];
    logic                    s1_v, s2_v, s1_l, s2_l;
    logic [7:0]              s1_x, s1_y, s2_x, s2_y;
    logic                    issue, pop, last_xy, start_ok;
    logic [ADDR_WIDTH-1:0]   base_lut [NUM_OCTAVES];

    for (genvar g = 0; g < NUM_OCTAVES; g++) begin : g_base
        assign base_lut[g] = base_of(g);
    end

    // octave geometry, issue/pop qualifiers and start validation
    always_comb begin
        x_max    = 8'((WIDTH >> oct) - 1);
        y_max    = 8'((HEIGHT >> oct) - 1);
        sh_w     = 5'(LW) - 5'(oct);
        sh_hw    = sh_w + 5'(LH) - 5'(oct);
        last_xy  = x == x_max && y == y_max;
        issue    = state == ISSUE && credits != '0;
        pop      = count != '0 && pixel_ready_in;
        start_ok = 32'(octave_in) < NUM_OCTAVES && 32'(blur_in) < NUM_BLURS;
    end

    assign bram_en_out     = issue;
    assign bram_addr_out   = base_lut[oct] + (ADDR_WIDTH'(blur) << sh_hw)
                           + (ADDR_WIDTH'(y) << sh_w) + ADDR_WIDTH'(x);
    assign pixel_valid_out = count != '0;
    assign {pixel_out, pixel_x_out, pixel_y_out, pixel_last_out} = pixel_valid_out ? mem[rd_ptr] : '0;

    // request FSM: accept/reject start, walk the raster, wait for the stream to drain
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            oct       <= '0;
            blur      <= '0;
            x         <= '0;
            y         <= '0;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            error_out <= 1'b0;
        end else begin
            done_out  <= 1'b0;
            error_out <= 1'b0;
            case (state)
                IDLE: if (start_in) begin
                    if (start_ok) begin
                        oct      <= octave_in;
                        blur     <= blur_in;
                        x        <= '0;
                        y        <= '0;
                        busy_out <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        error_out <= 1'b1;
                    end
                end
                ISSUE: if (issue) begin
                    x <= x == x_max ? '0 : x + 8'd1;
                    y <= x == x_max ? y + 8'd1 : y;
                    if (last_xy) state <= DRAIN;
                end
                DRAIN: if (credits == CW'(FIFO_DEPTH)) begin
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // credits, 2-stage read-latency pipeline and FIFO pointers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            credits <= CW'(FIFO_DEPTH);
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            {s1_v, s1_x, s1_y, s1_l} <= '0;
            {s2_v, s2_x, s2_y, s2_l} <= '0;
        end else begin
            credits <= credits - CW'(issue) + CW'(pop);
            count   <= count + CW'(s2_v) - CW'(pop);
            {s1_v, s1_x, s1_y, s1_l} <= {issue, x, y, last_xy};
            {s2_v, s2_x, s2_y, s2_l} <= {s1_v, s1_x, s1_y, s1_l};
            if (s2_v) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are only visible while occupied
    always_ff @(posedge clk_in) begin
        if (s2_v) mem[wr_ptr] <= {bram_data_in, s2_x, s2_y, s2_l};
    end
endmodule
